// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the two-requester L2 request arbiter.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } arb_state_e;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int unsigned TAG_W_DEF    = 18;
    localparam int unsigned INDEX_W_DEF  = 8;
    localparam int unsigned OFFSET_W_DEF = 6;
    localparam int unsigned DATA_W_DEF   = 512;

endpackage

// File: rtl/l2_rr_pick.sv
// Combinational 2-way round-robin picker; on a tie the requester not granted last wins.
module l2_rr_pick
    import l2_arb_pkg::*;
(
    input  logic [1:0] i_pending,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_id
);

    always_comb begin
        o_valid = |i_pending;
        o_id    = REQ_I;
        if (&i_pending) begin
            o_id = ~i_last;
        end else if (i_pending[REQ_D]) begin
            o_id = REQ_D;
        end
    end

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares the L2 request port between the L1 I-cache (0) and D-cache (1); one transaction at a time,
// completion returned to the owner as a one-cycle ready pulse.
module l2_req_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned TAG_W    = TAG_W_DEF,
    parameter int unsigned INDEX_W  = INDEX_W_DEF,
    parameter int unsigned OFFSET_W = OFFSET_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            read_L1,
    input  logic [1:0]            write_L1,
    input  logic [2*TAG_W-1:0]    tag_L1,
    input  logic [2*INDEX_W-1:0]  index_L1,
    input  logic [2*OFFSET_W-1:0] offset_L1,
    input  logic [2*DATA_W-1:0]   write_data_L1,
    output logic [1:0]            ready_L1,
    output logic [DATA_W-1:0]     read_data_L1,
    output logic                  read_L1_L2,
    output logic                  write_L1_L2,
    output logic [TAG_W-1:0]      tag_L1_L2,
    output logic [INDEX_W-1:0]    index_L1_L2,
    output logic [OFFSET_W-1:0]   offset,
    output logic [DATA_W-1:0]     write_data,
    input  logic                  ready_L2_L1,
    input  logic [DATA_W-1:0]     read_data_L2_L1
);

    arb_state_e          r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_rd;
    logic                r_wr;
    logic [TAG_W-1:0]    r_tag;
    logic [INDEX_W-1:0]  r_index;
    logic [OFFSET_W-1:0] r_offset;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_resp;
    logic [1:0]          r_ready;

    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic [1:0]          w_pending;
    logic                w_gnt_wr;
    logic                w_gnt_rd;
    logic [TAG_W-1:0]    w_gnt_tag;
    logic [INDEX_W-1:0]  w_gnt_index;
    logic [OFFSET_W-1:0] w_gnt_offset;
    logic [DATA_W-1:0]   w_gnt_wdata;

    assign w_pending = read_L1 | write_L1;

    l2_rr_pick u_pick (
        .i_pending (w_pending),
        .i_last    (r_last),
        .o_valid   (w_gnt_valid),
        .o_id      (w_gnt_id)
    );

    // Write takes precedence when a requester raises both command bits.
    assign w_gnt_wr     = write_L1[w_gnt_id];
    assign w_gnt_rd     = read_L1[w_gnt_id] & ~w_gnt_wr;
    assign w_gnt_tag    = w_gnt_id ? tag_L1[TAG_W +: TAG_W]          : tag_L1[0 +: TAG_W];
    assign w_gnt_index  = w_gnt_id ? index_L1[INDEX_W +: INDEX_W]    : index_L1[0 +: INDEX_W];
    assign w_gnt_offset = w_gnt_id ? offset_L1[OFFSET_W +: OFFSET_W] : offset_L1[0 +: OFFSET_W];
    assign w_gnt_wdata  = w_gnt_id ? write_data_L1[DATA_W +: DATA_W] : write_data_L1[0 +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_tag    <= '0;
            r_index  <= '0;
            r_offset <= '0;
            r_wdata  <= '0;
            r_resp   <= '0;
            r_ready  <= '0;
        end else begin
            r_ready <= '0;
            case (r_state)
                StIdle: begin
                    if (w_gnt_valid) begin
                        r_owner  <= w_gnt_id;
                        r_last   <= w_gnt_id;
                        r_rd     <= w_gnt_rd;
                        r_wr     <= w_gnt_wr;
                        r_tag    <= w_gnt_tag;
                        r_index  <= w_gnt_index;
                        r_offset <= w_gnt_offset;
                        r_wdata  <= w_gnt_wdata;
                        r_state  <= StBusy;
                    end
                end
                StBusy: begin
                    if (ready_L2_L1) begin
                        r_resp           <= read_data_L2_L1;
                        r_rd             <= 1'b0;
                        r_wr             <= 1'b0;
                        r_ready[r_owner] <= 1'b1;
                        r_state          <= StResp;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign read_L1_L2   = r_rd;
    assign write_L1_L2  = r_wr;
    assign tag_L1_L2    = r_tag;
    assign index_L1_L2  = r_index;
    assign offset       = r_offset;
    assign write_data   = r_wdata;
    assign ready_L1     = r_ready;
    assign read_data_L1 = r_resp;

endmodule
